fft_sdf_stage: RTL and testbench
================================

# fft_sdf_stage

Parametrised radix-2 single-path delay-feedback (SDF) FFT stage: the generalised successor of the two-point stage, with configurable sample width, delay depth, optional per-stage scaling, an externally supplied twiddle, and valid gating. Cascading log2(N) instances (DEPTH = N/2, N/4, …, 1) with a twiddle source forms an N-point DIF pipeline FFT. Samples stream in one per accepted cycle; results stream out in SDF order.

## Interface
- DW, 12: signed sample width, real and imaginary each.
- DEPTH, 4: feedback delay length in samples; power of two, ≥1. Frame = 2·DEPTH samples.
- TW_FRAC, 10: twiddle fraction bits (Q1.TW_FRAC; 1024 = 1.0 at default).
- SCALE, 0: 1 = divide butterfly outputs by 2 (no overflow possible); 0 = full scale with saturation.

- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  sample accept strobe; stage advances only when high.
- in_r, in_i  in  DW  signed input sample.
- tw_r, tw_i  in  DW  signed twiddle for the current sample; sampled only in phase 1.
- ovf_clr  in  1  synchronous clear of ovf.
- out_valid  out  1  output sample valid.
- out_r, out_i  out  DW  signed output sample (registered).
- ovf  out  1  sticky saturation flag.

## Operation
- Counter cnt, log2(2·DEPTH) bits, increments on each accepted sample, wraps at 2·DEPTH. Phase = cnt MSB (DEPTH=1: the single bit).
- Delay line: DEPTH-entry FIFO of complex DW-bit words; pops head and pushes one word per accepted sample, never otherwise.
- Phase 0 (fill): out ← head; push input sample.
- Phase 1 (compute): a = head, b = input. s = a+b, d = a−b at DW+1 bits.
  - SCALE=1: s, d arithmetic-shifted right by 1 (floor).
  - out ← sat(s); push sat(round(d·tw)).
  - Complex product: pr = d_r·tw_r − d_i·tw_i, pi = d_r·tw_i + d_i·tw_r, full precision; round = add 2^(TW_FRAC−1) then >>> TW_FRAC.
  - sat(): clamp to [−2^(DW−1), 2^(DW−1)−1]; any clamp in a cycle sets ovf.
- Priming: primed flag set once DEPTH samples accepted after reset; out_valid ← in_valid & primed (so first DEPTH accepted samples produce no valid output; delay-line reset contents never emitted).
- ovf: set on saturation, cleared by ovf_clr; simultaneous set and clear → set wins.

## Timing
- Reset values: out_r=0, out_i=0, out_valid=0, ovf=0, cnt=0, primed=0, delay line all 0.
- Reset asserted mid-frame: all state cleared immediately; next accepted sample after release is phase 0, cnt=0.
- Output register updates one cycle after each accepted sample; holds value when in_valid=0; out_valid low for cycles without acceptance.
- Latency: input sample k emerges (as butterfly sum or delayed difference) DEPTH accepted samples later, plus one clock.
- in_valid gaps anywhere in a frame (including at wrap) change nothing but timing.
- Twiddle must be valid in the same cycle as the phase-1 sample it applies to; ignored in phase 0.

## Test plan
- DEPTH=2, SCALE=0, tw=(1024,0), real inputs 100,200,300,400, then 0,0,0,0 → out_valid first high after 3rd sample; outputs 400,600,−200,−200 (imag 0); ovf=0.
- Same stream, tw=(0,−1024) for samples 3–4 → differences emerge as (0,200),(0,200).
- SCALE=0, inputs (2047,0),(…),(2047,0) in phase 1 pairing → sum saturates to 2047, ovf=1; ovf_clr pulse → ovf=0; with SCALE=1 same data → output 2047, ovf stays 0.
- Rounding: d=(1,0), tw=(512,0), TW_FRAC=10 → pushed value 1 (0.5 rounds up); d=(−1,0) → 0.
- Random in_valid gaps (30% idle) over 8 frames, DEPTH=4 → output sequence identical to gap-free run; out_valid count equals accepted count minus 4.
- rst pulse in middle of phase 1 → outputs/ovf/out_valid zero asynchronously; next frame processed from cnt=0 with no valid output for first DEPTH samples.

Source files
------------

// File: rtl/fft_sdf_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : fft_sdf_stage_if
// Description : Streaming sample/twiddle bus of one radix-2 SDF FFT stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface fft_sdf_stage_if #(
    parameter int DW = 12
);
    logic                 in_valid;
    logic signed [DW-1:0] in_r;
    logic signed [DW-1:0] in_i;
    logic signed [DW-1:0] tw_r;
    logic signed [DW-1:0] tw_i;
    logic                 ovf_clr;
    logic                 out_valid;
    logic signed [DW-1:0] out_r;
    logic signed [DW-1:0] out_i;
    logic                 ovf;

    modport master (
        output in_valid, in_r, in_i, tw_r, tw_i, ovf_clr,
        input  out_valid, out_r, out_i, ovf
    );

    modport slave (
        input  in_valid, in_r, in_i, tw_r, tw_i, ovf_clr,
        output out_valid, out_r, out_i, ovf
    );
endinterface
`default_nettype wire

// File: rtl/fft_sdf_stage.sv
`default_nettype none
// ============================================================================
// Module      : fft_sdf_stage
// Description : Radix-2 single-path delay-feedback FFT stage with optional
//               per-stage halving, saturation and external twiddle.
// Revision    : 1.0 - initial release
// ============================================================================
module fft_sdf_stage #(
    parameter int DW      = 12,
    parameter int DEPTH   = 4,
    parameter int TW_FRAC = 10,
    parameter int SCALE   = 0
) (
    input  wire logic      clk,
    input  wire logic      rst,
    fft_sdf_stage_if.slave bus
);
    localparam int c_CW = (DEPTH > 1) ? $clog2(2 * DEPTH) : 1;
    localparam int c_PW = 2 * DW + 3;

    localparam logic signed [c_PW-1:0] c_MAX  = {{(c_PW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [c_PW-1:0] c_MIN  = {{(c_PW-DW+1){1'b1}}, {(DW-1){1'b0}}};
    localparam logic signed [c_PW-1:0] c_HALF = {{(c_PW-1){1'b0}}, 1'b1} << (TW_FRAC - 1);
    localparam logic [c_CW-1:0]        c_PRIME_AT = c_CW'(DEPTH - 1);

    function automatic logic signed [DW-1:0] f_sat(input logic signed [c_PW-1:0] x);
        if (x > c_MAX)
            f_sat = c_MAX[DW-1:0];
        else if (x < c_MIN)
            f_sat = c_MIN[DW-1:0];
        else
            f_sat = x[DW-1:0];
    endfunction

    function automatic logic f_clip(input logic signed [c_PW-1:0] x);
        f_clip = (x > c_MAX) || (x < c_MIN);
    endfunction

    logic [c_CW-1:0]      r_cnt;
    logic                 r_primed;
    logic signed [DW-1:0] r_dl_r [DEPTH];
    logic signed [DW-1:0] r_dl_i [DEPTH];
    logic                 r_out_valid;
    logic signed [DW-1:0] r_out_r;
    logic signed [DW-1:0] r_out_i;
    logic                 r_ovf;

    logic                   w_accept;
    logic                   w_phase;
    logic signed [DW-1:0]   w_a_r, w_a_i;
    logic signed [DW:0]     w_s_r, w_s_i, w_d_r, w_d_i;
    logic signed [DW:0]     w_ss_r, w_ss_i, w_dd_r, w_dd_i;
    logic signed [c_PW-1:0] w_sx_r, w_sx_i;
    logic signed [c_PW-1:0] w_dx_r, w_dx_i, w_twx_r, w_twx_i;
    logic signed [c_PW-1:0] w_pr, w_pi, w_rr, w_ri;
    logic signed [DW-1:0]   w_push_r, w_push_i;
    logic signed [DW-1:0]   w_res_r, w_res_i;
    logic                   w_ovf_set;

    assign w_accept = bus.in_valid;
    assign w_phase  = r_cnt[c_CW-1];
    assign w_a_r    = r_dl_r[DEPTH-1];
    assign w_a_i    = r_dl_i[DEPTH-1];

    // Butterfly at DW+1 bits so neither sum nor difference can wrap.
    assign w_s_r = $signed({w_a_r[DW-1], w_a_r}) + $signed({bus.in_r[DW-1], bus.in_r});
    assign w_s_i = $signed({w_a_i[DW-1], w_a_i}) + $signed({bus.in_i[DW-1], bus.in_i});
    assign w_d_r = $signed({w_a_r[DW-1], w_a_r}) - $signed({bus.in_r[DW-1], bus.in_r});
    assign w_d_i = $signed({w_a_i[DW-1], w_a_i}) - $signed({bus.in_i[DW-1], bus.in_i});

    assign w_ss_r = (SCALE != 0) ? (w_s_r >>> 1) : w_s_r;
    assign w_ss_i = (SCALE != 0) ? (w_s_i >>> 1) : w_s_i;
    assign w_dd_r = (SCALE != 0) ? (w_d_r >>> 1) : w_d_r;
    assign w_dd_i = (SCALE != 0) ? (w_d_i >>> 1) : w_d_i;

    assign w_sx_r  = {{(c_PW-DW-1){w_ss_r[DW]}}, w_ss_r};
    assign w_sx_i  = {{(c_PW-DW-1){w_ss_i[DW]}}, w_ss_i};
    assign w_dx_r  = {{(c_PW-DW-1){w_dd_r[DW]}}, w_dd_r};
    assign w_dx_i  = {{(c_PW-DW-1){w_dd_i[DW]}}, w_dd_i};
    assign w_twx_r = {{(c_PW-DW){bus.tw_r[DW-1]}}, bus.tw_r};
    assign w_twx_i = {{(c_PW-DW){bus.tw_i[DW-1]}}, bus.tw_i};

    // Full-precision complex multiply, then round half up before saturating.
    assign w_pr = w_dx_r * w_twx_r - w_dx_i * w_twx_i;
    assign w_pi = w_dx_r * w_twx_i + w_dx_i * w_twx_r;
    assign w_rr = (w_pr + c_HALF) >>> TW_FRAC;
    assign w_ri = (w_pi + c_HALF) >>> TW_FRAC;

    assign w_res_r  = w_phase ? f_sat(w_sx_r) : w_a_r;
    assign w_res_i  = w_phase ? f_sat(w_sx_i) : w_a_i;
    assign w_push_r = w_phase ? f_sat(w_rr) : bus.in_r;
    assign w_push_i = w_phase ? f_sat(w_ri) : bus.in_i;

    assign w_ovf_set = w_accept & w_phase &
                       (f_clip(w_sx_r) | f_clip(w_sx_i) | f_clip(w_rr) | f_clip(w_ri));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_primed    <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_r     <= '0;
            r_out_i     <= '0;
            r_ovf       <= 1'b0;
            for (int k = 0; k < DEPTH; k++) begin
                r_dl_r[k] <= '0;
                r_dl_i[k] <= '0;
            end
        end else begin
            r_out_valid <= w_accept & r_primed;
            if (w_accept) begin
                r_cnt   <= r_cnt + c_CW'(1);
                r_out_r <= w_res_r;
                r_out_i <= w_res_i;
                if (r_cnt == c_PRIME_AT)
                    r_primed <= 1'b1;
                // Shift register FIFO: push at index 0, head at DEPTH-1.
                for (int k = DEPTH - 1; k > 0; k--) begin
                    r_dl_r[k] <= r_dl_r[k-1];
                    r_dl_i[k] <= r_dl_i[k-1];
                end
                r_dl_r[0] <= w_push_r;
                r_dl_i[0] <= w_push_i;
            end
            if (w_ovf_set)
                r_ovf <= 1'b1;
            else if (bus.ovf_clr)
                r_ovf <= 1'b0;
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_r     = r_out_r;
    assign bus.out_i     = r_out_i;
    assign bus.ovf       = r_ovf;
endmodule
`default_nettype wire

// File: tb/tb_fft_sdf_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fft_sdf_stage
// Description : Directed self-checking bench for fft_sdf_stage (DEPTH 2 and 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_sdf_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fft_sdf_stage_if #(.DW(12)) if_a ();
    fft_sdf_stage_if #(.DW(12)) if_b ();

    fft_sdf_stage #(.DW(12), .DEPTH(2), .TW_FRAC(10), .SCALE(0)) u_a (
        .clk (clk),
        .rst (rst),
        .bus (if_a)
    );

    fft_sdf_stage #(.DW(12), .DEPTH(4), .TW_FRAC(10), .SCALE(1)) u_b (
        .clk (clk),
        .rst (rst),
        .bus (if_b)
    );

    logic                collect = 1'b0;
    logic signed [11:0]  got_r[$];
    logic signed [11:0]  got_i[$];

    always @(negedge clk) begin
        if (collect && if_b.out_valid === 1'b1) begin
            got_r.push_back(if_b.out_r);
            got_i.push_back(if_b.out_i);
        end
    end

    task automatic step_a(input bit v, input int r, input int i, input int twr, input int twi, input bit clr);
        @(negedge clk);
        if_a.in_valid = v;
        if_a.in_r     = 12'(r);
        if_a.in_i     = 12'(i);
        if_a.tw_r     = 12'(twr);
        if_a.tw_i     = 12'(twi);
        if_a.ovf_clr  = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic step_b(input bit v, input int r, input int i, input int twr, input int twi, input bit clr);
        @(negedge clk);
        if_b.in_valid = v;
        if_b.in_r     = 12'(r);
        if_b.in_i     = 12'(i);
        if_b.tw_r     = 12'(twr);
        if_b.tw_i     = 12'(twi);
        if_b.ovf_clr  = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        {if_a.in_valid, if_a.in_r, if_a.in_i, if_a.tw_r, if_a.tw_i, if_a.ovf_clr} = '0;
        {if_b.in_valid, if_b.in_r, if_b.in_i, if_b.tw_r, if_b.tw_i, if_b.ovf_clr} = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({if_a.out_valid, if_a.out_r, if_a.out_i, if_a.ovf} !== 26'd0) begin
            errors++;
            $display("FAIL reset_a: got v=%b r=%0d i=%0d ovf=%b, expected all zero",
                     if_a.out_valid, if_a.out_r, if_a.out_i, if_a.ovf);
        end
        checks++;
        if ({if_b.out_valid, if_b.out_r, if_b.out_i, if_b.ovf} !== 26'd0) begin
            errors++;
            $display("FAIL reset_b: got v=%b r=%0d i=%0d ovf=%b, expected all zero",
                     if_b.out_valid, if_b.out_r, if_b.out_i, if_b.ovf);
        end
    endtask

    task automatic test_basic();
        int ir [8] = '{100, 200, 300, 400, 0, 0, 0, 0};
        bit ev [8] = '{0, 0, 1, 1, 1, 1, 1, 1};
        int er [8] = '{0, 0, 400, 600, -200, -200, 0, 0};
        do_reset();
        for (int n = 0; n < 8; n++) begin
            step_a(1'b1, ir[n], 0, 1024, 0, 1'b0);
            checks++;
            if ({if_a.out_valid, if_a.out_r, if_a.out_i, if_a.ovf} !== {ev[n], 12'(er[n]), 12'sd0, 1'b0}) begin
                errors++;
                $display("FAIL basic[%0d]: got v=%b r=%0d i=%0d ovf=%b, expected v=%b r=%0d i=0 ovf=0",
                         n, if_a.out_valid, if_a.out_r, if_a.out_i, if_a.ovf, ev[n], er[n]);
            end
        end
        step_a(1'b0, 55, 66, 1024, 0, 1'b0);
        checks++;
        if ({if_a.out_valid, if_a.out_r} !== {1'b0, 12'sd0}) begin
            errors++;
            $display("FAIL basic_hold: got v=%b r=%0d, expected v=0 r=0", if_a.out_valid, if_a.out_r);
        end
    endtask

    task automatic test_twiddle();
        int ir  [8] = '{100, 200, 300, 400, 0, 0, 0, 0};
        int twr [8] = '{0, 0, 0, 0, 1024, 1024, 1024, 1024};
        int twi [8] = '{-1024, -1024, -1024, -1024, 0, 0, 0, 0};
        int er  [8] = '{0, 0, 400, 600, 0, 0, 0, 0};
        int ei  [8] = '{0, 0, 0, 0, 200, 200, 0, 0};
        do_reset();
        for (int n = 0; n < 8; n++) begin
            step_a(1'b1, ir[n], 0, twr[n], twi[n], 1'b0);
            checks++;
            if ({if_a.out_r, if_a.out_i} !== {12'(er[n]), 12'(ei[n])}) begin
                errors++;
                $display("FAIL twiddle[%0d]: got r=%0d i=%0d, expected r=%0d i=%0d",
                         n, if_a.out_r, if_a.out_i, er[n], ei[n]);
            end
        end
    endtask

    task automatic test_saturation();
        bit iv  [12] = '{1, 1, 1, 1, 0, 1, 1, 1, 0, 1, 1, 1};
        int ir  [12] = '{2047, 2047, 2047, 2047, 0, -2048, -2048, -2048, 0, 2047, 0, 0};
        bit clr [12] = '{0, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0};
        bit ev  [12] = '{0, 0, 1, 1, 0, 1, 1, 1, 0, 1, 1, 1};
        int er  [12] = '{0, 0, 2047, 2047, 2047, 0, 0, -2048, -2048, -1, 0, -2048};
        bit eo  [12] = '{0, 0, 1, 1, 0, 0, 0, 1, 0, 1, 1, 1};
        do_reset();
        for (int n = 0; n < 12; n++) begin
            step_a(iv[n], ir[n], 0, 1024, 0, clr[n]);
            checks++;
            if ({if_a.out_valid, if_a.out_r, if_a.ovf} !== {ev[n], 12'(er[n]), eo[n]}) begin
                errors++;
                $display("FAIL saturation[%0d]: got v=%b r=%0d ovf=%b, expected v=%b r=%0d ovf=%b",
                         n, if_a.out_valid, if_a.out_r, if_a.ovf, ev[n], er[n], eo[n]);
            end
        end
    endtask

    task automatic test_rounding();
        int ir  [6] = '{1, 0, 0, 1, 0, 0};
        int twr [6] = '{1024, 1024, 512, 512, 1024, 1024};
        int er  [6] = '{0, 0, 1, 1, 1, 0};
        do_reset();
        for (int n = 0; n < 6; n++) begin
            step_a(1'b1, ir[n], 0, twr[n], 0, 1'b0);
            checks++;
            if ({if_a.out_r, if_a.out_i} !== {12'(er[n]), 12'sd0}) begin
                errors++;
                $display("FAIL rounding[%0d]: got r=%0d i=%0d, expected r=%0d i=0",
                         n, if_a.out_r, if_a.out_i, er[n]);
            end
        end
    endtask

    task automatic test_midreset();
        int ir [4] = '{10, 20, 30, 40};
        bit ev [4] = '{0, 0, 1, 1};
        int er [4] = '{0, 0, 40, 60};
        do_reset();
        for (int n = 0; n < 3; n++)
            step_a(1'b1, 2047, 0, 1024, 0, 1'b0);
        checks++;
        if ({if_a.out_valid, if_a.ovf} !== 2'b11) begin
            errors++;
            $display("FAIL midreset_pre: got v=%b ovf=%b, expected v=1 ovf=1", if_a.out_valid, if_a.ovf);
        end
        #2;
        rst = 1'b1;
        if_a.in_valid = 1'b0;
        #1;
        checks++;
        if ({if_a.out_valid, if_a.out_r, if_a.out_i, if_a.ovf} !== 26'd0) begin
            errors++;
            $display("FAIL midreset_async: got v=%b r=%0d i=%0d ovf=%b, expected all zero",
                     if_a.out_valid, if_a.out_r, if_a.out_i, if_a.ovf);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 4; n++) begin
            step_a(1'b1, ir[n], 0, 1024, 0, 1'b0);
            checks++;
            if ({if_a.out_valid, if_a.out_r} !== {ev[n], 12'(er[n])}) begin
                errors++;
                $display("FAIL midreset_post[%0d]: got v=%b r=%0d, expected v=%b r=%0d",
                         n, if_a.out_valid, if_a.out_r, ev[n], er[n]);
            end
        end
    endtask

    task automatic test_gaps();
        int xr [64];
        int xi [64];
        int exp_r[$];
        int exp_i[$];
        int accepted = 0;
        for (int n = 0; n < 64; n++) begin
            xr[n] = int'($urandom_range(0, 2000)) - 1000;
            xi[n] = int'($urandom_range(0, 2000)) - 1000;
        end
        // SCALE=1, unity twiddle: frame f emits diffs of frame f-1 then sums of frame f.
        for (int f = 0; f < 8; f++) begin
            if (f > 0) begin
                for (int k = 0; k < 4; k++) begin
                    exp_r.push_back((xr[8*(f-1)+k] - xr[8*(f-1)+k+4]) >>> 1);
                    exp_i.push_back((xi[8*(f-1)+k] - xi[8*(f-1)+k+4]) >>> 1);
                end
            end
            for (int k = 0; k < 4; k++) begin
                exp_r.push_back((xr[8*f+k] + xr[8*f+k+4]) >>> 1);
                exp_i.push_back((xi[8*f+k] + xi[8*f+k+4]) >>> 1);
            end
        end
        do_reset();
        got_r.delete();
        got_i.delete();
        collect = 1'b1;
        for (int n = 0; n < 64; n++) begin
            while ($urandom_range(0, 9) < 3)
                step_b(1'b0, 0, 0, 1024, 0, 1'b0);
            step_b(1'b1, xr[n], xi[n], 1024, 0, 1'b0);
            accepted++;
        end
        repeat (3) step_b(1'b0, 0, 0, 1024, 0, 1'b0);
        collect = 1'b0;
        checks++;
        if (got_r.size() != accepted - 4) begin
            errors++;
            $display("FAIL gaps_count: got %0d valid outputs, expected %0d", got_r.size(), accepted - 4);
        end else begin
            for (int n = 0; n < exp_r.size(); n++) begin
                checks++;
                if ({got_r[n], got_i[n]} !== {12'(exp_r[n]), 12'(exp_i[n])}) begin
                    errors++;
                    $display("FAIL gaps[%0d]: got r=%0d i=%0d, expected r=%0d i=%0d",
                             n, got_r[n], got_i[n], exp_r[n], exp_i[n]);
                end
            end
        end
    endtask

    task automatic test_scale();
        do_reset();
        for (int n = 0; n < 8; n++) begin
            step_b(1'b1, 2047, 0, 1024, 0, 1'b0);
            if (n >= 4) begin
                checks++;
                if ({if_b.out_valid, if_b.out_r, if_b.out_i, if_b.ovf} !== {1'b1, 12'sd2047, 12'sd0, 1'b0}) begin
                    errors++;
                    $display("FAIL scale[%0d]: got v=%b r=%0d i=%0d ovf=%b, expected v=1 r=2047 i=0 ovf=0",
                             n, if_b.out_valid, if_b.out_r, if_b.out_i, if_b.ovf);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_twiddle();
        test_saturation();
        test_rounding();
        test_midreset();
        test_gaps();
        test_scale();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
